// File: rtl/x_mult_pipeline_pkg.sv
// Shared definitions for the execute-stage pipelined multiplier.
// Optional feature macro: MULT_UMULH_EN (adds UMULH high-half support, 128-bit partial sums).
`ifndef X_MULT_PIPELINE_DEFS
`define X_MULT_PIPELINE_DEFS
`define ZERO_REG  6'd31
`define SD
`define REG_IDX_W 6
`endif

package x_mult_pipeline_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = `REG_IDX_W;
  localparam logic [REG_IDX_W-1:0] ZERO_REG_IDX = `ZERO_REG;

`ifdef MULT_UMULH_EN
  localparam int unsigned PSUM_W = 2 * XLEN;
`else
  localparam int unsigned PSUM_W = XLEN;
`endif

  // Payload carried from one multiplier stage to the next.
  typedef struct packed {
    logic                 valid;
    logic                 umulh;
    logic [REG_IDX_W-1:0] dest;
    logic [PSUM_W-1:0]    mcand;
    logic [XLEN-1:0]      mplier;
    logic [PSUM_W-1:0]    psum;
  } mult_bus_t;

  localparam mult_bus_t BUS_RESET = '{
    valid:  1'b0,
    umulh:  1'b0,
    dest:   ZERO_REG_IDX,
    mcand:  '0,
    mplier: '0,
    psum:   '0
  };

endpackage

// File: rtl/x_mult_pipeline_mult_stage.sv
// One multiplier pipeline stage: adds one SLICE_W-bit partial product and registers the result.
module mult_stage
  import x_mult_pipeline_pkg::*;
#(
  parameter int unsigned STAGE_IDX = 0,
  parameter int unsigned SLICE_W   = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      flush_i,
  input  mult_bus_t bus_i,
  output mult_bus_t bus_o
);

  localparam int unsigned SHIFT = STAGE_IDX * SLICE_W;

  logic [SLICE_W-1:0] mplier_slice;
  logic [PSUM_W-1:0]  pprod;
  mult_bus_t          bus_d;
  mult_bus_t          bus_q;

  // Partial product of this stage's multiplier slice, accumulated into the running sum.
  always_comb begin
    mplier_slice = bus_i.mplier[SHIFT +: SLICE_W];
    pprod        = (bus_i.mcand << SHIFT) * PSUM_W'(mplier_slice);
    bus_d        = bus_i;
    bus_d.valid  = bus_i.valid & ~flush_i;
    bus_d.psum   = bus_i.psum + pprod;
  end

  // Stage register; a flush only clears valid, datapath keeps whatever it had.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_q <= BUS_RESET;
    end else begin
      bus_q <= bus_d;
    end
  end

  assign bus_o = bus_q;

endmodule

// File: rtl/x_mult_pipeline.sv
// Fully pipelined 64x64 multiplier, one issue per cycle, latency STAGES.
// Optional feature macro: MULT_UMULH_EN (X_umulh_in selects product[127:64]).
module x_mult_pipeline
  import x_mult_pipeline_pkg::*;
#(
  parameter int unsigned STAGES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [XLEN-1:0]               X_mcand_in,
  input  logic [XLEN-1:0]               X_mplier_in,
  input  logic                          X_valid_inst_in,
  input  logic [REG_IDX_W-1:0]          X_dest_reg_idx_in,
  input  logic                          X_flush_in,
`ifdef MULT_UMULH_EN
  input  logic                          X_umulh_in,
`endif
  output logic [XLEN-1:0]               X_alu_result_out,
  output logic                          X_valid_inst_out,
  output logic [REG_IDX_W-1:0]          X_dest_reg_idx_out,
  output logic [$clog2(STAGES+1)-1:0]   X_mult_inflight_out
);

  localparam int unsigned SLICE_W = XLEN / STAGES;
  localparam int unsigned CNT_W   = $clog2(STAGES + 1);

  mult_bus_t          issue_bus;
  mult_bus_t          stage_bus [STAGES];
  mult_bus_t          tail;
  logic [STAGES-1:0]  stage_valid;
  logic [CNT_W-1:0]   inflight_cnt;
  logic [XLEN-1:0]    result_sel;
  logic               unused_tail;

  // Pack the issue-port operands into the stage-0 payload.
  always_comb begin
    issue_bus        = BUS_RESET;
    issue_bus.valid  = X_valid_inst_in;
    issue_bus.dest   = X_dest_reg_idx_in;
    issue_bus.mcand  = PSUM_W'(X_mcand_in);
    issue_bus.mplier = X_mplier_in;
`ifdef MULT_UMULH_EN
    issue_bus.umulh  = X_umulh_in;
`else
    issue_bus.umulh  = 1'b0;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_bus_t stage_in;
    if (k == 0) begin : g_first
      assign stage_in = issue_bus;
    end else begin : g_chain
      assign stage_in = stage_bus[k-1];
    end

    mult_stage #(
      .STAGE_IDX (k),
      .SLICE_W   (SLICE_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .flush_i (X_flush_in),
      .bus_i   (stage_in),
      .bus_o   (stage_bus[k])
    );

    assign stage_valid[k] = stage_bus[k].valid;
  end

  // Popcount of stage valid bits; bounded by STAGES so it cannot wrap.
  always_comb begin
    inflight_cnt = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      inflight_cnt = inflight_cnt + CNT_W'(stage_valid[k]);
    end
  end

  assign tail = stage_bus[STAGES-1];

  // Select low or high product half; the last stage's operand copies are not needed.
`ifdef MULT_UMULH_EN
  assign result_sel  = tail.umulh ? tail.psum[2*XLEN-1:XLEN] : tail.psum[XLEN-1:0];
  assign unused_tail = ^{tail.mcand, tail.mplier};
`else
  assign result_sel  = tail.psum;
  assign unused_tail = ^{tail.mcand, tail.mplier, tail.umulh};
`endif

  assign X_valid_inst_out    = tail.valid;
  assign X_alu_result_out    = tail.valid ? result_sel : '0;
  assign X_dest_reg_idx_out  = tail.valid ? tail.dest : ZERO_REG_IDX;
  assign X_mult_inflight_out = inflight_cnt;

endmodule

// File: tb/tb_x_mult_pipeline.sv
// Directed self-checking bench for x_mult_pipeline (STAGES = 4).
`ifndef ZERO_REG
`define ZERO_REG 6'd31
`endif

module tb_x_mult_pipeline;

  localparam logic [5:0] ZR = `ZERO_REG;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] mcand, mplier;
  logic        valid_in;
  logic [5:0]  dest_in;
  logic        flush;
`ifdef MULT_UMULH_EN
  logic        umulh;
`endif
  logic [63:0] result;
  logic        valid_out;
  logic [5:0]  dest_out;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  x_mult_pipeline #(.STAGES(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .X_mcand_in          (mcand),
    .X_mplier_in         (mplier),
    .X_valid_inst_in     (valid_in),
    .X_dest_reg_idx_in   (dest_in),
    .X_flush_in          (flush),
`ifdef MULT_UMULH_EN
    .X_umulh_in          (umulh),
`endif
    .X_alu_result_out    (result),
    .X_valid_inst_out    (valid_out),
    .X_dest_reg_idx_out  (dest_out),
    .X_mult_inflight_out (inflight)
  );

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] d, input logic f);
    valid_in = v; mcand = a; mplier = b; dest_in = d; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 64'd0, 6'd0, 1'b0);
`ifdef MULT_UMULH_EN
    umulh = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic ev;
    reset = 1'b1;
    idle();
    #1;
    checks++;
    if ({valid_out, result, dest_out, inflight} !== {1'b0, 64'd0, ZR, 3'd0}) begin
      errors++;
      $display("FAIL reset_initial got v=%0b r=%h d=%0d n=%0d want 0/0/%0d/0",
               valid_out, result, dest_out, inflight, ZR);
    end
    step(); step();
    reset = 1'b0;
    drive(1'b1, 64'd9, 64'd9, 6'd2, 1'b0);
    step(); idle(); step(); step(); step();
    checks++;
    if ({valid_out, result, dest_out} !== {1'b1, 64'd81, 6'd2}) begin
      errors++;
      $display("FAIL pre_reset_op got v=%0b r=%h d=%0d want 1/51/2", valid_out, result, dest_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({valid_out, result, dest_out, inflight} !== {1'b0, 64'd0, ZR, 3'd0}) begin
      errors++;
      $display("FAIL reset_async got v=%0b r=%h d=%0d n=%0d want 0/0/%0d/0",
               valid_out, result, dest_out, inflight, ZR);
    end
    #2 reset = 1'b0;
    drive(1'b1, 64'd3, 64'd5, 6'd4, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      step(); idle();
      ev = (c == 4);
      checks++;
      if ({valid_out, result, dest_out} !== {ev, ev ? 64'd15 : 64'd0, ev ? 6'd4 : ZR}) begin
        errors++;
        $display("FAIL reset_first_op cyc=%0d got v=%0b r=%h d=%0d want v=%0b r=%h d=%0d",
                 c, valid_out, result, dest_out, ev, ev ? 64'd15 : 64'd0, ev ? 6'd4 : ZR);
      end
    end
  endtask

  // Drives n ops back-to-back from cycle 0 and checks each appears exactly 4 cycles later.
  task automatic run_vectors(input string name, input int n, input logic [63:0] va [8],
                             input logic [63:0] vb [8], input logic [63:0] vexp [8]);
    int idx;
    logic ev;
    logic [63:0] er;
    logic [5:0] ed;
    for (int c = 0; c < n + 5; c++) begin
      if (c < n) drive(1'b1, va[c], vb[c], 6'(c + 1), 1'b0);
      else idle();
      step();
      idx = c + 1 - 4;
      ev = (idx >= 0 && idx < n);
      er = ev ? vexp[idx] : 64'd0;
      ed = ev ? 6'(idx + 1) : ZR;
      checks++;
      if ({valid_out, result, dest_out} !== {ev, er, ed}) begin
        errors++;
        $display("FAIL %s cyc=%0d got v=%0b r=%h d=%0d want v=%0b r=%h d=%0d",
                 name, c + 1, valid_out, result, dest_out, ev, er, ed);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [63:0] a [8] = '{64'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 0, 0, 0, 0};
    logic [63:0] b [8] = '{64'd3, 64'd9, 64'd1, 64'h1_0000_0000, 0, 0, 0, 0};
    logic [63:0] e [8] = '{64'd6, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 0};
    run_vectors("back_to_back", 4, a, b, e);
  endtask

  task automatic test_arith();
    logic [63:0] a [8] = '{-64'sd3, -64'sd3, 64'h8000_0000_0000_0000,
                           64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF, 64'd3, 0, 0};
    logic [63:0] b [8] = '{-64'sd5, 64'd5, 64'd2, 64'd16, 64'hFFFF_FFFF,
                           64'hFFFF_0000_0000_0000, 0, 0};
    logic [63:0] e [8] = '{64'd15, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 64'h2345_6789_ABCD_EF00,
                           64'hFFFF_FFFE_0000_0001, 64'hFFFD_0000_0000_0000, 0, 0};
    run_vectors("arith", 6, a, b, e);
  endtask

  task automatic test_flush();
    logic ev;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 64'(c + 10), 64'd100, 6'(c + 20), 1'b0);
      step();
    end
    checks++;
    if ({inflight, valid_out} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL flush_full got n=%0d v=%0b want 4/1", inflight, valid_out);
    end
    drive(1'b1, 64'd5, 64'd5, 6'd7, 1'b1);
    step();
    checks++;
    if ({valid_out, inflight} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL flush_clear got v=%0b n=%0d want 0/0", valid_out, inflight);
    end
    drive(1'b1, 64'd11, 64'd13, 6'd9, 1'b0);
    step(); idle();
    for (int cyc = 6; cyc <= 10; cyc++) begin
      ev = (cyc == 9);
      checks++;
      if ({valid_out, result, dest_out} !== {ev, ev ? 64'd143 : 64'd0, ev ? 6'd9 : ZR}) begin
        errors++;
        $display("FAIL flush_after cyc=%0d got v=%0b r=%h d=%0d want v=%0b r=%h d=%0d",
                 cyc, valid_out, result, dest_out, ev, ev ? 64'd143 : 64'd0, ev ? 6'd9 : ZR);
      end
      step();
    end
  endtask

  task automatic test_inflight();
    logic [2:0]  en [9] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
    logic [63:0] er;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: drive(1'b1, 64'd4, 64'd5, 6'd1, 1'b0);
        1: drive(1'b1, 64'd6, 64'd7, 6'd2, 1'b0);
        3: drive(1'b1, 64'd8, 64'd9, 6'd3, 1'b0);
        default: idle();
      endcase
      step();
      checks++;
      if (inflight !== en[c] || inflight > 3'd4) begin
        errors++;
        $display("FAIL inflight cyc=%0d got %0d want %0d", c + 1, inflight, en[c]);
      end
      case (c + 1)
        4: er = 64'd20;
        5: er = 64'd42;
        7: er = 64'd72;
        default: er = 64'd0;
      endcase
      checks++;
      if ({valid_out, result} !== {er != 64'd0, er}) begin
        errors++;
        $display("FAIL inflight_result cyc=%0d got v=%0b r=%h want r=%h", c + 1, valid_out, result, er);
      end
    end
    idle();
  endtask

`ifdef MULT_UMULH_EN
  task automatic test_umulh();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5, 1'b0);
    umulh = 1'b1;
    step();
    umulh = 1'b0;
    step(); idle(); step(); step();
    checks++;
    if ({valid_out, result, dest_out} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 6'd5}) begin
      errors++;
      $display("FAIL umulh_high got v=%0b r=%h d=%0d want 1/fffffffffffffffe/5", valid_out, result, dest_out);
    end
    step();
    checks++;
    if ({valid_out, result} !== {1'b1, 64'd1}) begin
      errors++;
      $display("FAIL umulh_low got v=%0b r=%h want 1/1", valid_out, result);
    end
    step(); step();
  endtask
`endif

  task automatic test_reset_midflight();
    drive(1'b1, 64'd2, 64'd2, 6'd1, 1'b0);
    step();
    drive(1'b1, 64'd3, 64'd3, 6'd2, 1'b0);
    step(); idle();
    checks++;
    if (inflight !== 3'd2) begin
      errors++;
      $display("FAIL midflight_count got %0d want 2", inflight);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({inflight, valid_out} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midflight_reset got n=%0d v=%0b want 0/0", inflight, valid_out);
    end
    #2 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if ({valid_out, inflight} !== {1'b0, 3'd0}) begin
        errors++;
        $display("FAIL midflight_after cyc=%0d got v=%0b n=%0d want 0/0", c, valid_out, inflight);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_arith();
    test_flush();
    test_inflight();
`ifdef MULT_UMULH_EN
    test_umulh();
`endif
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
